// File: rtl/math_equation_acc.sv
//------------------------------------------------------------------------------
// math_equation_acc: per-frame sum/min/max/count of the math_equation result
// stream, delivered through a 2-entry ready/valid record FIFO.
//------------------------------------------------------------------------------
`default_nettype none

module math_equation_acc #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_i,
    input  logic signed [2*WIDTH+1:0]         q_i,
    input  logic        [LEN_W-1:0]           frame_len_i,
    input  logic                              flush_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic signed [2*WIDTH+2+LEN_W-1:0] sum_o,
    output logic signed [2*WIDTH+1:0]         min_o,
    output logic signed [2*WIDTH+1:0]         max_o,
    output logic        [LEN_W-1:0]           count_o,
    output logic                              drop_o
);

    localparam int IN_W  = 2*WIDTH+2;
    localparam int ACC_W = IN_W+LEN_W;
    localparam int REC_W = ACC_W+2*IN_W+LEN_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic signed [IN_W-1:0]  min_q, min_d;
    logic signed [IN_W-1:0]  max_q, max_d;

    logic signed [ACC_W-1:0] q_ext;
    logic                    close;
    logic [REC_W-1:0]        rec;

    assign q_ext = {{LEN_W{q_i[IN_W-1]}}, q_i};

    always_comb begin
        len_d = len_q;
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        cnt_d = cnt_q;
        close = 1'b0;
        if (valid_i) begin
            if (state_q == S_IDLE) begin
                len_d = (frame_len_i == '0) ? LEN_W'(1) : frame_len_i;
                sum_d = q_ext;
                min_d = q_i;
                max_d = q_i;
                cnt_d = LEN_W'(1);
            end else begin
                sum_d = sum_q + q_ext;
                min_d = (q_i < min_q) ? q_i : min_q;
                max_d = (q_i > max_q) ? q_i : max_q;
                cnt_d = cnt_q + LEN_W'(1);
            end
            close = (cnt_d == len_d) || flush_i;
        end else begin
            close = flush_i && (state_q == S_ACCUM);
        end
    end

    // The record is the post-update accumulator, so a closing sample is included.
    assign rec     = {sum_d, min_d, max_d, cnt_d};
    assign state_d = close ? S_IDLE : (valid_i ? S_ACCUM : state_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= close ? '0 : cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    // Output FIFO: head_q drives the outputs directly, tail_q is the second slot.
    logic [1:0]       fill_q;
    logic [REC_W-1:0] head_q, tail_q;
    logic             pop;
    logic             drop_q;

    assign valid_o = (fill_q != 2'd0);
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= close && (fill_q == 2'd2) && !pop;
            case (fill_q)
                2'd0: begin
                    if (close) begin
                        head_q <= rec;
                        fill_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (close && pop) begin
                        head_q <= rec;
                    end else if (close) begin
                        tail_q <= rec;
                        fill_q <= 2'd2;
                    end else if (pop) begin
                        fill_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (close) begin
                            tail_q <= rec;
                        end else begin
                            fill_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign sum_o   = head_q[REC_W-1 -: ACC_W];
    assign min_o   = head_q[2*IN_W+LEN_W-1 -: IN_W];
    assign max_o   = head_q[IN_W+LEN_W-1 -: IN_W];
    assign count_o = head_q[LEN_W-1:0];
    assign drop_o  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_math_equation_acc.sv
//------------------------------------------------------------------------------
// tb_math_equation_acc: directed frames with a record scoreboard and monitor.
//------------------------------------------------------------------------------
`default_nettype none

module tb_math_equation_acc;

    localparam int WIDTH = 16;
    localparam int LEN_W = 8;
    localparam int IN_W  = 2*WIDTH+2;
    localparam int ACC_W = IN_W+LEN_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_i;
    logic signed [IN_W-1:0]  q_i;
    logic [LEN_W-1:0]        frame_len_i;
    logic                    flush_i;
    logic                    valid_o;
    logic                    ready_i;
    logic signed [ACC_W-1:0] sum_o;
    logic signed [IN_W-1:0]  min_o;
    logic signed [IN_W-1:0]  max_o;
    logic [LEN_W-1:0]        count_o;
    logic                    drop_o;

    math_equation_acc #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .q_i(q_i),
        .frame_len_i(frame_len_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .sum_o(sum_o), .min_o(min_o), .max_o(max_o),
        .count_o(count_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint s;
        longint mn;
        longint mx;
        longint c;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_rec(input longint s, input longint mn,
                                       input longint mx, input longint c);
        rec_t r;
        r.s = s; r.mn = mn; r.mx = mx; r.c = c;
        exp_q.push_back(r);
    endfunction

    // Monitor: every accepted record is compared against the queue head.
    always @(negedge clk) begin
        if (rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_record: got sum %0d count %0d, none expected",
                         longint'(sum_o), count_o);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk("rec_sum",   longint'(sum_o), e.s);
                chk("rec_min",   longint'(min_o), e.mn);
                chk("rec_max",   longint'(max_o), e.mx);
                chk("rec_count", longint'(count_o), e.c);
            end
        end
    end

    task automatic smp(input longint v, input bit fl);
        valid_i = 1'b1;
        q_i     = v[IN_W-1:0];
        flush_i = fl;
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        idle();
        chk(name, longint'(exp_q.size()), 0);
    endtask

    longint P;
    longint N;

    initial begin
        rst = 1'b0; valid_i = 1'b0; q_i = '0; frame_len_i = '0;
        flush_i = 1'b0; ready_i = 1'b0;
        P = (longint'(1) <<< 33) - 1;
        N = -(longint'(1) <<< 33);

        #2;
        chk("reset_valid", longint'(valid_o), 0);
        chk("reset_drop",  longint'(drop_o), 0);
        chk("reset_sum",   longint'(sum_o), 0);
        chk("reset_min",   longint'(min_o), 0);
        chk("reset_max",   longint'(max_o), 0);
        chk("reset_count", longint'(count_o), 0);
        idle(); idle();
        rst = 1'b1;
        idle();

        // Basic 4-sample frame; record visible one cycle after the last sample.
        ready_i = 1'b1; frame_len_i = 8'd4;
        expect_rec(-6, -20, 10, 4);
        smp(10, 0); smp(-3, 0); smp(7, 0); smp(-20, 0);
        chk("t1_latency_valid", longint'(valid_o), 1);
        drain("t1_drained");

        // Early flush with the closing sample, then a new frame closed by a bare flush.
        frame_len_i = 8'd8;
        expect_rec(14, 5, 9, 2);
        expect_rec(1, 1, 1, 1);
        smp(5, 0); smp(9, 1); smp(1, 0);
        chk("t2_new_frame_count", longint'(dut.cnt_q), 1);
        flush_i = 1'b1; idle(); flush_i = 1'b0;
        flush_i = 1'b1; idle(); flush_i = 1'b0;   // idle flush: no record
        drain("t2_drained");

        // Length 0 acts as 1; FIFO fills and the third record is dropped.
        ready_i = 1'b0; frame_len_i = 8'd0;
        expect_rec(1, 1, 1, 1);
        expect_rec(2, 2, 2, 1);
        smp(1, 0); smp(2, 0); smp(3, 0);
        chk("t3_drop_pulse", longint'(drop_o), 1);
        idle();
        chk("t3_drop_clear", longint'(drop_o), 0);
        chk("t3_hold_valid", longint'(valid_o), 1);
        chk("t3_hold_head",  longint'(sum_o), 1);
        ready_i = 1'b1;
        drain("t3_drained");
        chk("t3_empty_valid", longint'(valid_o), 0);

        // Full-length frames at the positive and negative extremes.
        frame_len_i = 8'd255;
        expect_rec(255*P, P, P, 255);
        for (int i = 0; i < 255; i++) smp(P, 0);
        drain("t4_pos_drained");
        expect_rec(255*N, N, N, 255);
        for (int i = 0; i < 255; i++) smp(N, 0);
        drain("t4_neg_drained");

        // Full FIFO with a pop and a push on the same edge: no drop.
        ready_i = 1'b0; frame_len_i = 8'd1;
        expect_rec(7, 7, 7, 1);
        expect_rec(8, 8, 8, 1);
        expect_rec(9, 9, 9, 1);
        smp(7, 0); smp(8, 0);
        ready_i = 1'b1;
        smp(9, 0);
        chk("t5_no_drop", longint'(drop_o), 0);
        drain("t5_drained");

        // Asynchronous reset mid-frame with a pending record.
        ready_i = 1'b0; frame_len_i = 8'd1;
        smp(50, 0);
        frame_len_i = 8'd4;
        smp(100, 0); smp(200, 0); smp(300, 0);
        chk("t6_pre_reset_valid", longint'(valid_o), 1);
        #3 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_valid", longint'(valid_o), 0);
        chk("t6_async_count", longint'(count_o), 0);
        idle();
        rst = 1'b1;
        ready_i = 1'b1;
        expect_rec(10, 1, 4, 4);
        smp(1, 0); smp(2, 0); smp(3, 0); smp(4, 0);
        drain("t6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/math_equation_acc.md
Name: math_equation_acc

Overview:
- Downstream stage of the math_equation pipeline.
- Consumes its valid/q result stream (one signed 2*WIDTH+2-bit result per valid cycle, no backpressure).
- Groups results into frames of programmable length and computes sum, min, max and sample count per frame.
- Delivers one record per frame through a 2-entry ready/valid output FIFO to the result-collection logic.

Parameters:
- WIDTH, 16: operand width of the upstream math_equation; input result width IN_W = 2*WIDTH+2 (derived localparam).
- LEN_W, 8: width of the frame length and sample count; max frame = 2^LEN_W-1 samples.
- Derived localparam ACC_W = IN_W+LEN_W: sum width; no overflow possible.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- valid_i  input  1  upstream result valid (upstream valid_o).
- q_i  input  IN_W  signed upstream result.
- frame_len_i  input  LEN_W  samples per frame; sampled on the first sample of each frame; 0 is treated as 1.
- flush_i  input  1  close the current frame early.
- valid_o  output  1  frame record available (FIFO not empty).
- ready_i  input  1  consumer accepts record when valid_o&ready_i.
- sum_o  output  ACC_W  signed sum of frame samples.
- min_o  output  IN_W  signed minimum sample of frame.
- max_o  output  IN_W  signed maximum sample of frame.
- count_o  output  LEN_W  number of samples in frame.
- drop_o  output  1  one-cycle pulse: a completed frame was discarded (FIFO full).

Behaviour:
- Reset (rst=0, async):
  - FIFO empty; valid_o=0, drop_o=0.
  - sum_o/min_o/max_o/count_o=0.
  - Accumulator count=0; state IDLE. A partial frame is discarded.
- FSM:
  - IDLE: no samples in the frame.
  - ACCUM: count>=1.
  - IDLE->ACCUM on valid_i when the latched length is >1 and no flush.
  - ACCUM->IDLE on frame close.
  - A frame closes in IDLE on valid_i when the length is 1, or on valid_i&flush_i.
- First sample of a frame (valid_i in IDLE):
  - Latch len = (frame_len_i==0 ? 1 : frame_len_i).
  - sum = sign-extended q_i; min = max = q_i; count = 1.
  - frame_len_i changes during ACCUM are ignored until the next frame.
- Subsequent samples in ACCUM:
  - sum += q_i (signed, ACC_W).
  - min/max updated by signed compare; count += 1.
- Frame close:
  - Occurs on the cycle where the updated count == len, or where flush_i=1 and the updated count>=1.
  - A sample arriving with flush_i in the same cycle is included.
  - flush_i with count=0 and no valid_i: no effect.
  - On close, the record {sum,min,max,count} is pushed into the FIFO and the accumulator returns to IDLE.
  - A valid_i on the next cycle starts a new frame; no dead cycle.
- Latency: a record is visible on valid_o/outputs in the cycle after the closing sample's valid_i edge (1 cycle).
- FIFO:
  - 2 entries, in-order.
  - Outputs show the head entry and are stable while valid_o=1 and ready_i=0.
  - Pop when valid_o&ready_i.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Push when full with no pop: record discarded, FIFO unchanged, drop_o=1 for the next cycle only.
  - Accumulation never stalls; valid_i is never refused.
- Output registers hold their last head value when the FIFO is empty; valid_o qualifies them.

Test Plan:
- frame_len_i=4; valid_i samples 10,-3,7,-20 on consecutive cycles, ready_i=1 -> one cycle after the 4th sample: valid_o=1, sum_o=-6, min_o=-20, max_o=10, count_o=4; pops the same cycle.
- frame_len_i=8; samples 5,9; flush_i asserted with 9 -> record sum=14, min=5, max=9, count=2. A sample 1 on the next cycle starts a new frame with count=1.
- ready_i=0, frame_len_i=0 (treated as 1); samples 1,2,3 -> records 1 and 2 held, drop_o pulses once after sample 3. Then ready_i=1 -> records 1 then 2 pop in order, valid_o falls.
- frame_len_i=255; 255 samples of 2^33-1 (WIDTH=16) -> sum_o=255*(2^33-1), count_o=255. Repeat with -2^33 -> sum_o=-255*2^33, no wrap.
- FIFO full, ready_i=1 and a frame close in the same cycle -> no drop_o, head advances, new record stored behind it.
- Mid-frame (count=3 of 4): assert rst=0 asynchronously -> valid_o=0 immediately. After release, 4 new samples produce a record with count=4 containing only post-reset samples.
